// File: rtl/fp_argmax_stream.sv
// Streaming argmax over N_CLASS IEEE-754 scores, valid/ready on both sides.
// Define ARGMAX_TOP2_EN to also report the runner-up on m_idx2/m_max2.
module fp_argmax_stream #(
    parameter int  N_CLASS = 10,
    parameter int  EXP_W   = 8,
    parameter int  MAN_W   = 23,
    localparam int DATA_W  = 1 + EXP_W + MAN_W,
    localparam int IDX_W   = $clog2(N_CLASS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [IDX_W-1:0]  m_idx,
    output logic [DATA_W-1:0] m_max,
    output logic              m_err,
`ifdef ARGMAX_TOP2_EN
    output logic [IDX_W-1:0]  m_idx2,
    output logic [DATA_W-1:0] m_max2,
`endif
    output logic              m_all_nan
);

    typedef enum logic [1:0] {ACC, OUT, DRAIN} state_e;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CLASS - 1);
    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic is_nan(input logic [DATA_W-1:0] x);
        return (&x[DATA_W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    // Monotone unsigned key: -0 folds onto +0, negatives are bit-inverted.
    function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] c;
        c = (x[DATA_W-2:0] == '0) ? '0 : x;
        return c[DATA_W-1] ? ~c : (c ^ SIGN_BIT);
    endfunction

    // Strict "a beats b"; NaN loses to every non-NaN value.
    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (is_nan(a)) return 1'b0;
        if (is_nan(b)) return 1'b1;
        return order_key(a) > order_key(b);
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic              long_q, long_d;
    logic              ready_q, ready_d;
    logic              acc_xfer;
    logic              first_el;
    logic              take_max;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch below can infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        max_d    = max_q;
        idx_d    = idx_q;
        err_d    = err_q;
        long_d   = long_q;
        acc_xfer = (state_q == ACC) && s_valid && ready_q;
        first_el = (count_q == '0);
        take_max = !first_el && greater(s_data, max_q);

        unique case (state_q)
            ACC: begin
                if (acc_xfer) begin
                    if (first_el || take_max) begin
                        max_d = s_data;
                        idx_d = count_q;
                    end
                    count_d = count_q + IDX_W'(1);
                    if (s_last || (count_q == LAST_IDX)) begin
                        state_d = OUT;
                        err_d   = !s_last || (count_q != LAST_IDX);
                        long_d  = !s_last;
                    end
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = long_q ? DRAIN : ACC;
                    count_d = '0;
                end
            end
            DRAIN: begin
                if (s_valid && ready_q && s_last) state_d = ACC;
            end
            default: state_d = ACC;
        endcase

        // Registered so s_ready stays low for the first cycle out of reset.
        ready_d = (state_d != OUT);
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            count_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            long_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            long_q  <= long_d;
            ready_q <= ready_d;
        end
    end

    assign s_ready   = ready_q;
    assign m_valid   = (state_q == OUT);
    assign m_idx     = idx_q;
    assign m_max     = max_q;
    assign m_err     = err_q;
    assign m_all_nan = is_nan(max_q);

`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0] sec_q, sec_d;
    logic [IDX_W-1:0]  idx2_q, idx2_d;
    logic              sec_vld_q, sec_vld_d;

    always_comb begin
        sec_d     = sec_q;
        idx2_d    = idx2_q;
        sec_vld_d = sec_vld_q;
        if (acc_xfer) begin
            if (first_el) begin
                sec_d     = '0;
                idx2_d    = '0;
                sec_vld_d = 1'b0;
            end else if (take_max) begin
                sec_d     = max_q;
                idx2_d    = idx_q;
                sec_vld_d = 1'b1;
            end else if (!sec_vld_q || greater(s_data, sec_q)) begin
                sec_d     = s_data;
                idx2_d    = count_q;
                sec_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q     <= '0;
            idx2_q    <= '0;
            sec_vld_q <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            idx2_q    <= idx2_d;
            sec_vld_q <= sec_vld_d;
        end
    end

    assign m_idx2 = idx2_q;
    assign m_max2 = sec_q;
`else
    // Single-winner build: no runner-up datapath.
`endif

endmodule

// File: doc/fp_argmax_stream.md
Name: fp_argmax_stream

Overview:
- Streaming argmax over an N_CLASS-element vector of IEEE-754 binary floating-point scores. It is the generalised successor of the fixed 10-input classifier argmax.
- Elements arrive serially on a valid/ready stream. The block keeps a running maximum and returns the winning index and value on a valid/ready result port.
- It sits after the softmax/final dense layer and drives the digit-decision logic.
- Ordering logic is in-house combinational; no vendor FP IP.

Parameters:
- N_CLASS, 10, number of elements per vector (>=2).
- EXP_W, 8, exponent width of the FP format.
- MAN_W, 23, mantissa width. DATA_W = 1+EXP_W+MAN_W.
- IDX_W, $clog2(N_CLASS), index width (derived localparam, not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  block can accept an element.
- s_data  in  DATA_W  FP score.
- s_last  in  1  marks final element of a vector.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_idx  out  IDX_W  index (0-based arrival order) of the maximum.
- m_max  out  DATA_W  maximum value, bit-exact copy of the winning input.
- m_err  out  1  vector length error (see Behaviour).
- m_all_nan  out  1  every element of the vector was NaN.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_idx=0, m_max=0, m_err=0, m_all_nan=0. State=ACC, count=0. s_ready rises the cycle after rst deasserts.
- A transfer occurs on a clock edge where valid && ready.
- States:
  - ACC: s_ready=1, m_valid=0. On each input transfer, element k = count.
    - k==0: load max=s_data, idx=0.
    - k>0: replace max/idx only if s_data is strictly greater than max.
    - count increments on each transfer.
    - The vector terminates on the transfer where s_last=1 or count==N_CLASS-1, whichever comes first; go to OUT.
  - OUT: s_ready=0, m_valid=1, outputs stable. On m_valid && m_ready: go to ACC, count=0, m_valid=0 next cycle.
- Latency: m_valid asserts the cycle after the terminating transfer.
- Throughput: one element per cycle. Each vector costs one extra bubble per result handshake, plus any m_ready stall.
- Ordering:
  - Canonicalise -0 to +0.
  - key = sign ? ~x : x ^ MSB. Compare keys unsigned.
  - Ties (including +0 vs -0) keep the lower index, so the first occurrence wins.
- NaN (exponent all ones, mantissa != 0) compares less than every non-NaN value, including -Inf.
  - If k==0 is NaN, it is replaced by the first non-NaN element.
  - If all elements are NaN: m_idx=0, m_max=element 0, m_all_nan=1.
- ±Inf are ordinary values: +Inf beats everything and -Inf loses to all non-NaN values.
- m_err=1 if s_last arrives with count < N_CLASS-1 (short vector; result covers only the received elements), or if count reaches N_CLASS-1 with s_last=0 (long vector).
  - In the long-vector case, result is emitted for the first N_CLASS elements. The remaining elements up to and including the s_last element are then consumed and discarded: s_ready=1 in a DRAIN state after the result handshake, and no result is emitted for them.
- rst mid-vector or while in OUT aborts all state. The partial vector and any pending result are discarded.
- s_data is ignored when s_valid=0. m_* outputs must not change while m_valid=1 and m_ready=0.

Optional Feature:
- Macro ARGMAX_TOP2_EN.
- Defined: adds ports m_idx2 (IDX_W) and m_max2 (DATA_W), the runner-up under the same ordering and tie rules.
  - On replace of the maximum, the old max moves to second place.
  - Otherwise, an element strictly greater than second (or the first valid element at k==1) replaces second.
  - For a vector of length 1: m_idx2=0, m_max2=0.
  - Both ports reset to 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Basic vector: 10 back-to-back elements 0.1,0.3,0.05,0.9,0.2,0.0,0.1,0.4,0.8,0.7, s_last on the 10th, m_ready=1 → m_valid the cycle after the last transfer, m_idx=3, m_max=32'h3F666666, m_err=0.
- Ties and zeros: elements -0.0, +0.0, then 8×-1.0 → m_idx=0. Then 0.5 at indices 2 and 6, others 0.1 → m_idx=2.
- NaN/Inf: element 0 = 32'h7FC00000, element 4 = 32'hFF800000, others NaN → m_idx=4, m_all_nan=0. All ten NaN → m_idx=0, m_all_nan=1.
- Backpressure and length errors:
  - Hold m_ready=0 for 5 cycles → s_ready=0, outputs stable; result accepted on the first m_ready=1.
  - s_last on the 6th element → m_err=1, argmax taken over 6 elements.
  - 12 elements with s_last on the 12th → m_err=1, result over the first 10, elements 11–12 drained with no extra result.
- Reset mid-vector: rst pulsed after 4 transfers, then a clean vector whose max is at index 7 → m_idx=7, no stale result emitted.
- ARGMAX_TOP2_EN: the basic vector → m_idx=3, m_idx2=8, m_max2=32'h3F4CCCCD.
